control_decoder_fsm: RTL and testbench
======================================

Name: control_decoder_fsm

Overview:
- Parametrised, multi-cycle successor to the single-cycle instruction decoder. Owns the instruction-register handshake, decodes one instruction per transaction and drives datapath controls (register mux/demux selects, ALU op, RAM write, PC load and increment).
- Waits on RAM acknowledge for LOAD/STORE, with timeout. Halts stickily on FIN.
- Sits between the instruction memory / PC and the register file, ALU and RAM datapath.

Parameters:
- INSTR_W, 24, instruction width.
- OPCODE_W, 5, opcode field width; occupies the top bits.
- REG_SEL_W, 3, register-select field width (RegA, RegB, RegC).
- NUM_GPR, 8, register-file entries; index 0 is AC.
- ALU_CTRL_W, 4, ALU control width.
- DATA_W, 24, IMMEDIATE output width.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- INSTRUCTION  in  INSTR_W  instruction word.
- INSTR_VALID  in  1  INSTRUCTION is valid.
- INSTR_READY  out  1  decoder accepts an instruction.
- Z, N  in  1 each  ALU zero and negative flags.
- MEM_ACK  in  1  RAM has completed the access.
- INC_PC, LOAD_REG, WRITE, DMUX_A_SEL  out  1 each  control strobes and selects.
- MUX_A_SEL, MUX_B_SEL  out  REG_SEL_W  ALU operand register selects.
- MUX_C_SEL  out  2  write-back source: 0 ALU, 1 RAM, 2 immediate.
- DMUX_B_SEL  out  clog2(NUM_GPR+2)  destination: GPR index, MAR=NUM_GPR, PC=NUM_GPR+1.
- ALU_CONTROL  out  ALU_CTRL_W  ALU operation.
- IMMEDIATE  out  DATA_W  zero-extended immediate.
- FINISH, ILLEGAL, MEM_ERR, BUSY  out  1 each  status.

Behaviour:
- Field layout, MSB first:
  - opcode, then RegA, RegB, RegC.
  - IMM_L = low INSTR_W-OPCODE_W bits.
  - IMM_S = low INSTR_W-OPCODE_W-REG_SEL_W bits.
- Opcode map: NOP 0, LOAD 1, STORE 2, MOVE 3, LDMAR 4, LDMARI 5, LOADI 6, LDACI 7, ADD..XOR 8..18, JGT 19, JEQ 20, JGE 21, JLT 22, JNE 23, JLE 24, JMP 25, FIN 26.
- ALU codes: ADD 1, SUB 2, MUL 3, DIV 4, INC 5, DEC 6, NEG 7, NOT 8, AND 9, OR 10, XOR 11.
- Reset:
  - state IDLE.
  - All outputs 0, including FINISH, ILLEGAL and MEM_ERR.
  - INSTR_READY forced 0 while rst=1.
- Reset mid-MEM_WAIT drops WRITE at that edge and discards the instruction.
- States: IDLE, EXEC, MEM_WAIT, HALT.
- IDLE:
  - INSTR_READY=1; all control outputs 0.
  - On INSTR_VALID: latch INSTRUCTION, Z and N, and register the decoded control word; then go to EXEC, or to MEM_WAIT for LOAD/STORE.
  - Control outputs are therefore valid in the cycle after acceptance.
- EXEC lasts one cycle:
  - LOAD_REG and INC_PC are single-cycle pulses.
  - Jump taken: LOAD_REG=1, DMUX_B_SEL=PC, MUX_C_SEL=2, IMMEDIATE=IMM_L, INC_PC=0.
  - Jump not taken: INC_PC=1 only.
  - Jump conditions use the flags latched at acceptance:
    - JGT !Z&!N
    - JEQ Z
    - JGE !N
    - JLT !Z&N
    - JNE !Z
    - JLE Z|N
  - Next state IDLE. Peak throughput: 1 instruction per 2 cycles.
- MEM_WAIT:
  - STORE: MUX_B_SEL=RegA, DMUX_A_SEL=1, WRITE held 1 until the MEM_ACK cycle inclusive.
  - LOAD: MUX_C_SEL=1, DMUX_B_SEL=RegA; LOAD_REG=1 only in the cycle MEM_ACK=1.
  - On MEM_ACK: INC_PC=1 that cycle, then IDLE.
  - A wait counter increments each cycle. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without MEM_ACK:
    - WRITE and LOAD_REG stay 0.
    - MEM_ERR and INC_PC pulse for 1 cycle.
    - Return to IDLE.
  - MEM_ACK arriving in the same cycle as the timeout: the ack wins.
  - MEM_ACK outside MEM_WAIT is ignored.
- HALT, entered from FIN:
  - FINISH=1 sticky, INSTR_READY=0, all strobes 0.
  - Left only via rst.
- BUSY=1 in EXEC and MEM_WAIT.
- INC, DEC and NEG use RegA as both source and destination. NOT uses RegB/RegC.
- LDMARI and LDACI take IMM_L. LOADI takes IMM_S.
- Immediates are zero-extended or truncated to DATA_W.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined: an opcode above 26 enters HALT with ILLEGAL=1 sticky and FINISH=0.
- Undefined: an opcode above 26 executes as NOP (INC_PC pulse), and ILLEGAL is tied 0.

Decomposition:
- Package proc_isa_pkg:
  - opcode localparams.
  - ALU code localparams.
  - MUX_C source encodings.
  - state enum.
  - MAR/PC destination offsets.
- Sub-module isa_field_decode: combinational IR + flags -> control word. The FSM registers that word and sequences it.

Test Plan:
- ADD R3=R1+R2, INSTRUCTION=24'h432800 with a valid handshake:
  - Next cycle: MUX_A_SEL=1, MUX_B_SEL=2, ALU_CONTROL=1, DMUX_B_SEL=3, LOAD_REG=1, INC_PC=1, each for 1 cycle.
  - INSTR_READY then returns to 1.
- LOADI R2 0x1234, 24'h321234: IMMEDIATE=0x001234, MUX_C_SEL=2, DMUX_B_SEL=2. JEQ 24'hA00040:
  - With Z=1: DMUX_B_SEL=9, IMMEDIATE=0x40, INC_PC=0.
  - With Z=0: only INC_PC=1.
- STORE R4, 24'h140000, with MEM_ACK on the 3rd wait cycle:
  - WRITE=1 for 3 cycles, MUX_B_SEL=4, DMUX_A_SEL=1.
  - INC_PC pulses in the ack cycle; the next instruction is accepted 1 cycle later.
- LOAD R5, 24'h0D0000, no MEM_ACK, MEM_TIMEOUT=16:
  - MEM_ERR and INC_PC pulse after 16 wait cycles; LOAD_REG never asserts.
  - Repeat with rst asserted on wait cycle 5: all outputs 0 next cycle, state IDLE.
- FIN, 24'hD00000: FINISH=1 and INSTR_READY=0 held for 20+ cycles despite INSTR_VALID=1; rst clears both.
- Opcode 24'hF80000:
  - With ILLEGAL_OPCODE_TRAP_EN: ILLEGAL=1, halted.
  - Without: INC_PC pulse, ILLEGAL=0.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// proc_isa_pkg: ISA constants shared by the control decoder and its field decoder.
// Opcode numbers, ALU operation codes, write-back source encodings, FSM states,
// special destination offsets and the conditional-jump predicate.
package proc_isa_pkg;

   // Opcode map
   localparam int OP_NOP    = 0;
   localparam int OP_LOAD   = 1;
   localparam int OP_STORE  = 2;
   localparam int OP_MOVE   = 3;
   localparam int OP_LDMAR  = 4;
   localparam int OP_LDMARI = 5;
   localparam int OP_LOADI  = 6;
   localparam int OP_LDACI  = 7;
   localparam int OP_ADD    = 8;
   localparam int OP_INC    = 12;
   localparam int OP_DEC    = 13;
   localparam int OP_NEG    = 14;
   localparam int OP_XOR    = 18;
   localparam int OP_JGT    = 19;
   localparam int OP_JEQ    = 20;
   localparam int OP_JGE    = 21;
   localparam int OP_JLT    = 22;
   localparam int OP_JNE    = 23;
   localparam int OP_JLE    = 24;
   localparam int OP_JMP    = 25;
   localparam int OP_FIN    = 26;

   // ALU operation codes; ADD..XOR opcodes map onto ALU_ADD..ALU_XOR in order
   localparam int ALU_ADD = 1;
   localparam int ALU_SUB = 2;
   localparam int ALU_MUL = 3;
   localparam int ALU_DIV = 4;
   localparam int ALU_INC = 5;
   localparam int ALU_DEC = 6;
   localparam int ALU_NEG = 7;
   localparam int ALU_NOT = 8;
   localparam int ALU_AND = 9;
   localparam int ALU_OR  = 10;
   localparam int ALU_XOR = 11;

   // Write-back source (MUX_C) encodings
   localparam logic [1:0] MUXC_ALU = 2'd0;
   localparam logic [1:0] MUXC_RAM = 2'd1;
   localparam logic [1:0] MUXC_IMM = 2'd2;

   // Special destinations sit just above the GPR range
   localparam int DEST_MAR_OFS = 0;
   localparam int DEST_PC_OFS  = 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   // Condition for a jump opcode given the flags latched at acceptance
   function automatic logic jump_taken(input int op, input logic z, input logic n);
      logic taken;
      taken = 1'b0;
      case (op)
         OP_JGT:  taken = !z && !n;
         OP_JEQ:  taken = z;
         OP_JGE:  taken = !n;
         OP_JLT:  taken = !z && n;
         OP_JNE:  taken = !z;
         OP_JLE:  taken = z || n;
         OP_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/isa_field_decode.sv
// isa_field_decode: purely combinational split of an instruction word (plus the
// ALU flags sampled with it) into the datapath control word. The sequencing FSM
// registers this word at acceptance. Optional macro ILLEGAL_OPCODE_TRAP_EN makes
// opcodes above FIN report is_illegal instead of behaving as NOP.
module isa_field_decode
   import proc_isa_pkg::*;
#(
   parameter int INSTR_W    = 24,
   parameter int OPCODE_W   = 5,
   parameter int REG_SEL_W  = 3,
   parameter int NUM_GPR    = 8,
   parameter int ALU_CTRL_W = 4,
   parameter int DATA_W     = 24
) (
   input  logic [INSTR_W-1:0]             instruction,
   input  logic                           z,
   input  logic                           n,
   output logic [REG_SEL_W-1:0]           mux_a_sel,
   output logic [REG_SEL_W-1:0]           mux_b_sel,
   output logic [1:0]                     mux_c_sel,
   output logic                           dmux_a_sel,
   output logic [$clog2(NUM_GPR+2)-1:0]   dmux_b_sel,
   output logic [ALU_CTRL_W-1:0]          alu_control,
   output logic [DATA_W-1:0]              immediate,
   output logic                           load_reg,
   output logic                           inc_pc,
   output logic                           is_load,
   output logic                           is_store,
   output logic                           is_fin,
   output logic                           is_illegal
);

   localparam int IMM_L_W = INSTR_W - OPCODE_W;
   localparam int IMM_S_W = INSTR_W - OPCODE_W - REG_SEL_W;
   localparam int DB_W    = $clog2(NUM_GPR + 2);

   logic [OPCODE_W-1:0]  opcode;
   logic [REG_SEL_W-1:0] reg_a;
   logic [REG_SEL_W-1:0] reg_b;
   logic [REG_SEL_W-1:0] reg_c;
   logic [DATA_W-1:0]    imm_l;
   logic [DATA_W-1:0]    imm_s;
   int                   op;

   assign opcode = instruction[INSTR_W-1 -: OPCODE_W];
   assign reg_a  = instruction[INSTR_W-OPCODE_W-1 -: REG_SEL_W];
   assign reg_b  = instruction[INSTR_W-OPCODE_W-REG_SEL_W-1 -: REG_SEL_W];
   assign reg_c  = instruction[INSTR_W-OPCODE_W-2*REG_SEL_W-1 -: REG_SEL_W];
   assign imm_l  = DATA_W'(instruction[IMM_L_W-1:0]);
   assign imm_s  = DATA_W'(instruction[IMM_S_W-1:0]);
   assign op     = 32'(opcode);

   // Map the opcode class onto selects, ALU op, immediate and strobes
   always_comb begin
      mux_a_sel   = '0;
      mux_b_sel   = '0;
      mux_c_sel   = MUXC_ALU;
      dmux_a_sel  = 1'b0;
      dmux_b_sel  = '0;
      alu_control = '0;
      immediate   = '0;
      load_reg    = 1'b0;
      inc_pc      = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_fin      = 1'b0;
      is_illegal  = 1'b0;
      if (op >= OP_ADD && op <= OP_XOR) begin
         // ALU ops write RegA; unary INC/DEC/NEG also read RegA
         alu_control = ALU_CTRL_W'(op - OP_ADD + ALU_ADD);
         dmux_b_sel  = DB_W'(reg_a);
         load_reg    = 1'b1;
         inc_pc      = 1'b1;
         if (op == OP_INC || op == OP_DEC || op == OP_NEG) begin
            mux_a_sel = reg_a;
         end else begin
            mux_a_sel = reg_b;
            mux_b_sel = reg_c;
         end
      end else if (op >= OP_JGT && op <= OP_JMP) begin
         if (jump_taken(op, z, n)) begin
            load_reg   = 1'b1;
            dmux_b_sel = DB_W'(NUM_GPR + DEST_PC_OFS);
            mux_c_sel  = MUXC_IMM;
            immediate  = imm_l;
         end else begin
            inc_pc = 1'b1;
         end
      end else begin
         case (op)
            OP_NOP: inc_pc = 1'b1;
            OP_LOAD: begin
               is_load    = 1'b1;
               mux_c_sel  = MUXC_RAM;
               dmux_b_sel = DB_W'(reg_a);
            end
            OP_STORE: begin
               is_store   = 1'b1;
               mux_b_sel  = reg_a;
               dmux_a_sel = 1'b1;
            end
            OP_MOVE: begin
               // RegA <= RegB through the ALU pass-through (code 0)
               mux_a_sel  = reg_b;
               dmux_b_sel = DB_W'(reg_a);
               load_reg   = 1'b1;
               inc_pc     = 1'b1;
            end
            OP_LDMAR: begin
               mux_a_sel  = reg_a;
               dmux_b_sel = DB_W'(NUM_GPR + DEST_MAR_OFS);
               load_reg   = 1'b1;
               inc_pc     = 1'b1;
            end
            OP_LDMARI: begin
               mux_c_sel  = MUXC_IMM;
               immediate  = imm_l;
               dmux_b_sel = DB_W'(NUM_GPR + DEST_MAR_OFS);
               load_reg   = 1'b1;
               inc_pc     = 1'b1;
            end
            OP_LOADI: begin
               mux_c_sel  = MUXC_IMM;
               immediate  = imm_s;
               dmux_b_sel = DB_W'(reg_a);
               load_reg   = 1'b1;
               inc_pc     = 1'b1;
            end
            OP_LDACI: begin
               mux_c_sel  = MUXC_IMM;
               immediate  = imm_l;
               dmux_b_sel = '0;
               load_reg   = 1'b1;
               inc_pc     = 1'b1;
            end
            OP_FIN: is_fin = 1'b1;
            default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
               is_illegal = 1'b1;
`else
               inc_pc = 1'b1;
`endif
            end
         endcase
      end
   end

endmodule

// File: rtl/control_decoder_fsm.sv
// control_decoder_fsm: multi-cycle instruction decoder. Accepts one instruction
// per handshake in IDLE, registers its decoded control word, then drives it for
// one EXEC cycle or sequences a RAM access in MEM_WAIT (ack or timeout). FIN, and
// unknown opcodes when ILLEGAL_OPCODE_TRAP_EN is defined, park it in HALT until rst.
// The MEM_WAIT timeout fires in wait cycle MEM_TIMEOUT, so a RAM access never
// occupies more than MEM_TIMEOUT cycles; MEM_TIMEOUT=0 waits forever.
module control_decoder_fsm
   import proc_isa_pkg::*;
#(
   parameter int INSTR_W     = 24,
   parameter int OPCODE_W    = 5,
   parameter int REG_SEL_W   = 3,
   parameter int NUM_GPR     = 8,
   parameter int ALU_CTRL_W  = 4,
   parameter int DATA_W      = 24,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [INSTR_W-1:0]             INSTRUCTION,
   input  logic                           INSTR_VALID,
   output logic                           INSTR_READY,
   input  logic                           Z,
   input  logic                           N,
   input  logic                           MEM_ACK,
   output logic                           INC_PC,
   output logic                           LOAD_REG,
   output logic                           WRITE,
   output logic                           DMUX_A_SEL,
   output logic [REG_SEL_W-1:0]           MUX_A_SEL,
   output logic [REG_SEL_W-1:0]           MUX_B_SEL,
   output logic [1:0]                     MUX_C_SEL,
   output logic [$clog2(NUM_GPR+2)-1:0]   DMUX_B_SEL,
   output logic [ALU_CTRL_W-1:0]          ALU_CONTROL,
   output logic [DATA_W-1:0]              IMMEDIATE,
   output logic                           FINISH,
   output logic                           ILLEGAL,
   output logic                           MEM_ERR,
   output logic                           BUSY
);

   localparam int DB_W  = $clog2(NUM_GPR + 2);
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   // Decoded word straight from the instruction bus
   logic [REG_SEL_W-1:0]  dec_mux_a;
   logic [REG_SEL_W-1:0]  dec_mux_b;
   logic [1:0]            dec_mux_c;
   logic                  dec_dmux_a;
   logic [DB_W-1:0]       dec_dmux_b;
   logic [ALU_CTRL_W-1:0] dec_alu;
   logic [DATA_W-1:0]     dec_imm;
   logic                  dec_load_reg;
   logic                  dec_inc_pc;
   logic                  dec_is_load;
   logic                  dec_is_store;
   logic                  dec_is_fin;
   logic                  dec_is_illegal;

   // Control word registered at acceptance
   state_t                state_reg;
   logic [REG_SEL_W-1:0]  mux_a_reg;
   logic [REG_SEL_W-1:0]  mux_b_reg;
   logic [1:0]            mux_c_reg;
   logic                  dmux_a_reg;
   logic [DB_W-1:0]       dmux_b_reg;
   logic [ALU_CTRL_W-1:0] alu_reg;
   logic [DATA_W-1:0]     imm_reg;
   logic                  ld_strobe_reg;
   logic                  inc_strobe_reg;
   logic                  is_load_reg;
   logic                  is_store_reg;
   logic                  illegal_reg;
   logic [CNT_W-1:0]      wait_cnt_reg;

   logic                  timeout_hit;
   logic                  mem_timeout;

   isa_field_decode #(
      .INSTR_W    (INSTR_W),
      .OPCODE_W   (OPCODE_W),
      .REG_SEL_W  (REG_SEL_W),
      .NUM_GPR    (NUM_GPR),
      .ALU_CTRL_W (ALU_CTRL_W),
      .DATA_W     (DATA_W)
   ) u_decode (
      .instruction (INSTRUCTION),
      .z           (Z),
      .n           (N),
      .mux_a_sel   (dec_mux_a),
      .mux_b_sel   (dec_mux_b),
      .mux_c_sel   (dec_mux_c),
      .dmux_a_sel  (dec_dmux_a),
      .dmux_b_sel  (dec_dmux_b),
      .alu_control (dec_alu),
      .immediate   (dec_imm),
      .load_reg    (dec_load_reg),
      .inc_pc      (dec_inc_pc),
      .is_load     (dec_is_load),
      .is_store    (dec_is_store),
      .is_fin      (dec_is_fin),
      .is_illegal  (dec_is_illegal)
   );

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         assign timeout_hit = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // An ack in the timeout cycle takes precedence over the error
   assign mem_timeout = timeout_hit && !MEM_ACK;

   // State sequencing and capture of the decoded word on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mux_a_reg      <= '0;
         mux_b_reg      <= '0;
         mux_c_reg      <= '0;
         dmux_a_reg     <= 1'b0;
         dmux_b_reg     <= '0;
         alu_reg        <= '0;
         imm_reg        <= '0;
         ld_strobe_reg  <= 1'b0;
         inc_strobe_reg <= 1'b0;
         is_load_reg    <= 1'b0;
         is_store_reg   <= 1'b0;
         illegal_reg    <= 1'b0;
         wait_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (INSTR_VALID) begin
                  mux_a_reg      <= dec_mux_a;
                  mux_b_reg      <= dec_mux_b;
                  mux_c_reg      <= dec_mux_c;
                  dmux_a_reg     <= dec_dmux_a;
                  dmux_b_reg     <= dec_dmux_b;
                  alu_reg        <= dec_alu;
                  imm_reg        <= dec_imm;
                  ld_strobe_reg  <= dec_load_reg;
                  inc_strobe_reg <= dec_inc_pc;
                  is_load_reg    <= dec_is_load;
                  is_store_reg   <= dec_is_store;
                  wait_cnt_reg   <= '0;
                  if (dec_is_fin || dec_is_illegal) begin
                     illegal_reg <= dec_is_illegal;
                     state_reg   <= ST_HALT;
                  end else if (dec_is_load || dec_is_store) begin
                     state_reg <= ST_MEM_WAIT;
                  end else begin
                     state_reg <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: state_reg <= ST_IDLE;
            ST_MEM_WAIT: begin
               if (MEM_ACK || timeout_hit) begin
                  state_reg    <= ST_IDLE;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            ST_HALT: state_reg <= ST_HALT;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Drive datapath controls from the state and the registered control word
   always_comb begin
      INSTR_READY = 1'b0;
      INC_PC      = 1'b0;
      LOAD_REG    = 1'b0;
      WRITE       = 1'b0;
      DMUX_A_SEL  = 1'b0;
      MUX_A_SEL   = '0;
      MUX_B_SEL   = '0;
      MUX_C_SEL   = '0;
      DMUX_B_SEL  = '0;
      ALU_CONTROL = '0;
      IMMEDIATE   = '0;
      FINISH      = 1'b0;
      ILLEGAL     = 1'b0;
      MEM_ERR     = 1'b0;
      BUSY        = 1'b0;
      case (state_reg)
         ST_IDLE: INSTR_READY = !rst;
         ST_EXEC: begin
            BUSY        = 1'b1;
            MUX_A_SEL   = mux_a_reg;
            MUX_B_SEL   = mux_b_reg;
            MUX_C_SEL   = mux_c_reg;
            DMUX_A_SEL  = dmux_a_reg;
            DMUX_B_SEL  = dmux_b_reg;
            ALU_CONTROL = alu_reg;
            IMMEDIATE   = imm_reg;
            LOAD_REG    = ld_strobe_reg;
            INC_PC      = inc_strobe_reg;
         end
         ST_MEM_WAIT: begin
            BUSY       = 1'b1;
            MUX_B_SEL  = mux_b_reg;
            MUX_C_SEL  = mux_c_reg;
            DMUX_A_SEL = dmux_a_reg;
            DMUX_B_SEL = dmux_b_reg;
            WRITE      = is_store_reg && !mem_timeout;
            LOAD_REG   = is_load_reg && MEM_ACK;
            INC_PC     = MEM_ACK || mem_timeout;
            MEM_ERR    = mem_timeout;
         end
         ST_HALT: begin
            FINISH = !illegal_reg;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            ILLEGAL = illegal_reg;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_decoder_fsm.sv
// tb_control_decoder_fsm: directed scenarios plus randomized instruction stream,
// each cycle's outputs compared against an instruction-level reference model.
module tb_control_decoder_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] INSTRUCTION;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic        Z;
   logic        N;
   logic        MEM_ACK;
   logic        INC_PC;
   logic        LOAD_REG;
   logic        WRITE;
   logic        DMUX_A_SEL;
   logic [2:0]  MUX_A_SEL;
   logic [2:0]  MUX_B_SEL;
   logic [1:0]  MUX_C_SEL;
   logic [3:0]  DMUX_B_SEL;
   logic [3:0]  ALU_CONTROL;
   logic [23:0] IMMEDIATE;
   logic        FINISH;
   logic        ILLEGAL;
   logic        MEM_ERR;
   logic        BUSY;

`ifdef ILLEGAL_OPCODE_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int TMO = 16;

   typedef struct packed {
      logic        rdy;
      logic        inc;
      logic        ldr;
      logic        wr;
      logic        dma;
      logic [2:0]  ma;
      logic [2:0]  mb;
      logic [1:0]  mc;
      logic [3:0]  db;
      logic [3:0]  alu;
      logic [23:0] imm;
      logic        fin;
      logic        ill;
      logic        merr;
      logic        busy;
   } obs_t;

   obs_t dut_obs;
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   control_decoder_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .Z           (Z),
      .N           (N),
      .MEM_ACK     (MEM_ACK),
      .INC_PC      (INC_PC),
      .LOAD_REG    (LOAD_REG),
      .WRITE       (WRITE),
      .DMUX_A_SEL  (DMUX_A_SEL),
      .MUX_A_SEL   (MUX_A_SEL),
      .MUX_B_SEL   (MUX_B_SEL),
      .MUX_C_SEL   (MUX_C_SEL),
      .DMUX_B_SEL  (DMUX_B_SEL),
      .ALU_CONTROL (ALU_CONTROL),
      .IMMEDIATE   (IMMEDIATE),
      .FINISH      (FINISH),
      .ILLEGAL     (ILLEGAL),
      .MEM_ERR     (MEM_ERR),
      .BUSY        (BUSY)
   );

   always #5 clk = ~clk;

   assign dut_obs = {INSTR_READY, INC_PC, LOAD_REG, WRITE, DMUX_A_SEL, MUX_A_SEL,
                     MUX_B_SEL, MUX_C_SEL, DMUX_B_SEL, ALU_CONTROL, IMMEDIATE,
                     FINISH, ILLEGAL, MEM_ERR, BUSY};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic obs_t idle_exp();
      obs_t e;
      e = '0;
      e.rdy = 1'b1;
      return e;
   endfunction

   function automatic obs_t halt_exp(input logic ill);
      obs_t e;
      e = '0;
      e.fin = !ill;
      e.ill = ill;
      return e;
   endfunction

   // Single EXEC cycle of a non-memory, non-halting instruction
   function automatic obs_t model_exec(input logic [23:0] ins, input logic z, input logic n);
      obs_t       e;
      int         op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [2:0] rc;
      logic       taken;
      e     = '0;
      taken = 1'b0;
      op    = int'(ins[23:19]);
      ra    = ins[18:16];
      rb    = ins[15:13];
      rc    = ins[12:10];
      e.busy = 1'b1;
      if (op >= 8 && op <= 18) begin
         e.alu = 4'(op - 7);
         e.db  = {1'b0, ra};
         e.ldr = 1'b1;
         e.inc = 1'b1;
         if (op >= 12 && op <= 14) begin
            e.ma = ra;
         end else begin
            e.ma = rb;
            e.mb = rc;
         end
      end else if (op >= 19 && op <= 25) begin
         case (op)
            19: taken = !z && !n;
            20: taken = z;
            21: taken = !n;
            22: taken = !z && n;
            23: taken = !z;
            24: taken = z || n;
            default: taken = 1'b1;
         endcase
         if (taken) begin
            e.ldr = 1'b1;
            e.db  = 4'd9;
            e.mc  = 2'd2;
            e.imm = {5'd0, ins[18:0]};
         end else begin
            e.inc = 1'b1;
         end
      end else begin
         e.inc = 1'b1;
         case (op)
            3: begin e.ma = rb; e.db = {1'b0, ra}; e.ldr = 1'b1; end
            4: begin e.ma = ra; e.db = 4'd8; e.ldr = 1'b1; end
            5: begin e.mc = 2'd2; e.imm = {5'd0, ins[18:0]}; e.db = 4'd8; e.ldr = 1'b1; end
            6: begin e.mc = 2'd2; e.imm = {8'd0, ins[15:0]}; e.db = {1'b0, ra}; e.ldr = 1'b1; end
            7: begin e.mc = 2'd2; e.imm = {5'd0, ins[18:0]}; e.db = 4'd0; e.ldr = 1'b1; end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Wait cycle k (1-based) of a LOAD/STORE acked in cycle ack_at (0 = never)
   function automatic obs_t model_mem(input logic [23:0] ins, input int k, input int ack_at);
      obs_t       e;
      logic       ack;
      logic       tmo;
      logic [2:0] ra;
      e   = '0;
      ra  = ins[18:16];
      ack = (k == ack_at);
      tmo = !ack && (k == TMO);
      e.busy = 1'b1;
      if (ins[23:19] == 5'd2) begin
         e.mb  = ra;
         e.dma = 1'b1;
         e.wr  = !tmo;
      end else begin
         e.mc  = 2'd1;
         e.db  = {1'b0, ra};
         e.ldr = ack;
      end
      e.inc  = ack || tmo;
      e.merr = tmo;
      return e;
   endfunction

   // ---------------- stimulus tasks ----------------
   // Entry and exit: 1 time unit after a rising edge with the DUT idle
   // (or halted, for FIN / trapped opcodes).
   task automatic run_instr(input logic [23:0] ins, input logic z, input logic n, input int ack_at);
      int   op;
      int   k;
      bit   done;
      obs_t zero_exp;
      zero_exp = '0;
      op = int'(ins[23:19]);
      txn++;
      $display("txn %0d ins=%06h z=%0b n=%0b ack_at=%0d", txn, ins, z, n, ack_at);
      INSTRUCTION = ins;
      Z           = z;
      N           = n;
      INSTR_VALID = 1'b1;
      MEM_ACK     = 1'($urandom);
      #1 check_val("idle_accept", 64'(dut_obs), 64'(idle_exp()));
      @(posedge clk); #1;
      INSTR_VALID = 1'b0;
      INSTRUCTION = 24'($urandom);
      Z           = 1'($urandom);
      N           = 1'($urandom);
      MEM_ACK     = 1'b0;
      if (op == 1 || op == 2) begin
         k    = 1;
         done = 1'b0;
         while (!done) begin
            MEM_ACK = (k == ack_at);
            #1 check_val("mem_wait", 64'(dut_obs), 64'(model_mem(ins, k, ack_at)));
            done = (k == ack_at) || (k == TMO);
            @(posedge clk); #1;
            k++;
         end
         MEM_ACK = 1'b0;
      end else if (op == 26 || (TRAP && op > 26)) begin
         #1 check_val("halt_entry", 64'(dut_obs), 64'(halt_exp(op > 26)));
      end else begin
         MEM_ACK = 1'($urandom);
         #1 check_val("exec", 64'(dut_obs), 64'(model_exec(ins, z, n)));
         @(posedge clk); #1;
         MEM_ACK = 1'b0;
      end
      if (dut_obs == zero_exp) begin
         // never expected outside reset; keeps the exit state observable
         check_val("post_txn_nonzero", 64'(dut_obs), 64'(idle_exp()));
      end
   endtask

   task automatic do_reset();
      obs_t zero_exp;
      zero_exp    = '0;
      INSTR_VALID = 1'b0;
      rst         = 1'b1;
      #1 check_val("rdy_in_rst", 64'(INSTR_READY), 64'(0));
      @(posedge clk); #1;
      check_val("reset_zero", 64'(dut_obs), 64'(zero_exp));
      rst = 1'b0;
      #1 check_val("after_rst_idle", 64'(dut_obs), 64'(idle_exp()));
   endtask

   // Memory instruction with rst asserted in wait cycle rst_at
   task automatic mem_reset(input logic [23:0] ins, input int rst_at);
      txn++;
      $display("txn %0d ins=%06h reset_in_wait=%0d", txn, ins, rst_at);
      INSTRUCTION = ins;
      INSTR_VALID = 1'b1;
      MEM_ACK     = 1'b0;
      #1 check_val("idle_accept", 64'(dut_obs), 64'(idle_exp()));
      @(posedge clk); #1;
      INSTR_VALID = 1'b0;
      for (int k = 1; k < rst_at; k++) begin
         #1 check_val("mem_wait", 64'(dut_obs), 64'(model_mem(ins, k, 0)));
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1 check_val("rst_wait_cycle", 64'(dut_obs), 64'(model_mem(ins, rst_at, 0)));
      @(posedge clk); #1;
      check_val("rst_mid_wait_zero", 64'(dut_obs), 64'(0));
      rst = 1'b0;
      #1 check_val("after_rst_idle", 64'(dut_obs), 64'(idle_exp()));
   endtask

   initial begin
      int          op;
      logic [23:0] ins;
      obs_t        zero_exp;
      zero_exp    = '0;
      rst         = 1'b1;
      INSTR_VALID = 1'b0;
      INSTRUCTION = '0;
      Z           = 1'b0;
      N           = 1'b0;
      MEM_ACK     = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_val("reset_state", 64'(dut_obs), 64'(zero_exp));
      check_val("reset_ready", 64'(INSTR_READY), 64'(0));
      rst = 1'b0;
      #1 check_val("idle_after_reset", 64'(dut_obs), 64'(idle_exp()));

      // Directed scenarios
      run_instr(24'h432800, 1'b0, 1'b0, 0);   // ADD R3=R1+R2
      run_instr(24'h321234, 1'b0, 1'b0, 0);   // LOADI R2 0x1234
      run_instr(24'hA00040, 1'b1, 1'b0, 0);   // JEQ taken
      run_instr(24'hA00040, 1'b0, 1'b0, 0);   // JEQ not taken
      run_instr(24'h140000, 1'b0, 1'b0, 3);   // STORE R4, ack in wait cycle 3
      run_instr(24'h0D0000, 1'b0, 1'b0, 0);   // LOAD R5, timeout
      run_instr(24'h0D0000, 1'b0, 1'b0, TMO); // ack collides with timeout
      mem_reset(24'h0D0000, 5);
      mem_reset(24'h140000, 5);

      // FIN holds off new instructions until reset
      run_instr(24'hD00000, 1'b0, 1'b0, 0);
      for (int i = 0; i < 22; i++) begin
         INSTR_VALID = 1'b1;
         INSTRUCTION = 24'($urandom);
         MEM_ACK     = 1'($urandom);
         @(posedge clk); #1;
         check_val("halt_hold", 64'(dut_obs), 64'(halt_exp(1'b0)));
      end
      do_reset();

      // Opcode above FIN
      run_instr(24'hF80000, 1'b0, 1'b0, 0);
      if (TRAP) begin
         @(posedge clk); #1;
         check_val("trap_hold", 64'(dut_obs), 64'(halt_exp(1'b1)));
         do_reset();
      end

      // Randomized instruction stream
      for (int t = 0; t < 300; t++) begin
         op = $urandom_range(0, 31);
         if (op == 26 || (TRAP && op > 26)) op = $urandom_range(0, 25);
         ins = {5'(op), 19'($urandom)};
         run_instr(ins, 1'($urandom), 1'($urandom), $urandom_range(0, 20));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
